// File: rtl/input_command_queue.sv
// Button-event command queue: filters and prioritises one command per cycle,
// then buffers it in a show-ahead FIFO with a sticky overflow flag.
module input_command_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     game_active,
  input  logic                     reset_b,
  input  logic                     select_b,
  input  logic                     pause_b,
  input  logic                     left_b,
  input  logic                     right_b,
  input  logic                     rotate_b,
  input  logic                     hard_drop_b,
  input  logic                     soft_drop_b,
  input  logic                     hold_b,
  input  logic                     cmd_ready,
  output logic                     cmd_valid,
  output logic [3:0]               cmd_code,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = DEPTH[AW:0];

  typedef enum logic [3:0] {
    C_NONE  = 4'd0,
    C_LEFT  = 4'd1,
    C_RIGHT = 4'd2,
    C_ROT   = 4'd3,
    C_SOFT  = 4'd4,
    C_HARD  = 4'd5,
    C_HOLD  = 4'd6,
    C_PAUSE = 4'd7,
    C_SEL   = 4'd8,
    C_GRST  = 4'd9
  } cmd_e;

  cmd_e          cand;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          flush;
  logic          push;
  logic          pop;
  logic          accept;

  // Menu mode only listens to reset and select; left+right cancel out.
  always_comb begin
    cand = C_NONE;
    if (reset_b)                cand = C_GRST;
    else if (!game_active) begin
      if (select_b)             cand = C_SEL;
    end
    else if (pause_b)           cand = C_PAUSE;
    else if (hard_drop_b)       cand = C_HARD;
    else if (rotate_b)          cand = C_ROT;
    else if (hold_b)            cand = C_HOLD;
    else if (left_b ^ right_b)  cand = left_b ? C_LEFT : C_RIGHT;
    else if (soft_drop_b)       cand = C_SOFT;
  end

  assign full   = (count == CAP);
  assign flush  = (cand == C_GRST);
  assign push   = (cand != C_NONE) && !flush;
  assign pop    = cmd_valid && cmd_ready;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= AW'(1);
      count    <= (AW+1)'(1);
      overflow <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (accept && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !accept)
        count <= count - (AW+1)'(1);
      if (push && !accept)
        overflow <= 1'b1;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_in) begin
    if (flush)
      mem[0] <= C_GRST;
    else if (accept)
      mem[wr_ptr] <= cand;
  end

  assign cmd_valid = (count != '0);
  assign cmd_code  = cmd_valid ? mem[rd_ptr] : 4'd0;

endmodule

// File: tb/tb_input_command_queue.sv
// Scoreboarded bench for input_command_queue: directed scenarios plus
// randomized pulses against a queue-based reference model.
module tb_input_command_queue;

  localparam int DEPTH = 4;

  localparam logic [8:0] RST = 9'h001;
  localparam logic [8:0] SEL = 9'h002;
  localparam logic [8:0] PAU = 9'h004;
  localparam logic [8:0] LFT = 9'h008;
  localparam logic [8:0] RGT = 9'h010;
  localparam logic [8:0] ROT = 9'h020;
  localparam logic [8:0] HRD = 9'h040;
  localparam logic [8:0] SFT = 9'h080;
  localparam logic [8:0] HLD = 9'h100;

  logic       clk_in;
  logic       reset_in;
  logic       game_active;
  logic [8:0] btn;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic [2:0] count;
  logic       overflow;

  int n_chk;
  int n_fail;
  int exp_q[$];
  bit exp_ovf;

  input_command_queue #(.DEPTH(DEPTH)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .game_active (game_active),
    .reset_b     (btn[0]),
    .select_b    (btn[1]),
    .pause_b     (btn[2]),
    .left_b      (btn[3]),
    .right_b     (btn[4]),
    .rotate_b    (btn[5]),
    .hard_drop_b (btn[6]),
    .soft_drop_b (btn[7]),
    .hold_b      (btn[8]),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .count       (count),
    .overflow    (overflow)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference command selection straight from the priority rules.
  function automatic int pick(input bit ga, input logic [8:0] b);
    if (b[0]) return 9;
    if (!ga) return b[1] ? 8 : 0;
    if (b[2]) return 7;
    if (b[6]) return 5;
    if (b[5]) return 3;
    if (b[8]) return 6;
    if (b[3] && !b[4]) return 1;
    if (b[4] && !b[3]) return 2;
    if (b[7]) return 4;
    return 0;
  endfunction

  always @(posedge reset_in) begin
    exp_q.delete();
    exp_ovf = 0;
  end

  always @(posedge clk_in) begin
    int c;
    if (reset_in) begin
      exp_q.delete();
      exp_ovf = 0;
    end else begin
      c = pick(game_active, btn);
      if (c == 9) begin
        exp_q.delete();
        exp_q.push_back(9);
        exp_ovf = 0;
      end else begin
        if (cmd_ready && exp_q.size() != 0)
          void'(exp_q.pop_front());
        if (c != 0) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(c);
          else exp_ovf = 1;
        end
      end
    end
  end

  // Monitor: compare the presented head and status against the model.
  always @(negedge clk_in) begin
    check("mon_count", int'(count), exp_q.size());
    check("mon_overflow", int'(overflow), int'(exp_ovf));
    check("mon_valid", int'(cmd_valid), int'(exp_q.size() != 0));
    if (cmd_valid && exp_q.size() != 0)
      check("mon_code", int'(cmd_code), exp_q[0]);
    else if (!cmd_valid)
      check("mon_code_idle", int'(cmd_code), 0);
  end

  task automatic cyc(input logic [8:0] b, input logic rdy);
    btn = b;
    cmd_ready = rdy;
    @(posedge clk_in);
    #1;
    btn = '0;
    cmd_ready = 1'b0;
  endtask

  task automatic async_rst(input string tag);
    #2 reset_in = 1'b1;
    #1;
    check({tag, "_valid"}, int'(cmd_valid), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_code"}, int'(cmd_code), 0);
    @(posedge clk_in);
    #1 reset_in = 1'b0;
  endtask

  initial begin
    logic [8:0] b;
    n_chk = 0;
    n_fail = 0;
    exp_ovf = 0;
    reset_in = 1'b1;
    btn = '0;
    game_active = 1'b1;
    cmd_ready = 1'b0;
    #3;
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_code", int'(cmd_code), 0);
    check("rst_ovf", int'(overflow), 0);
    btn = LFT;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ignore", int'(count), 0);
    reset_in = 1'b0;
    btn = '0;

    cyc(LFT, 0);
    check("r28_lat", int'(cmd_valid), 1);
    cyc(ROT, 0);
    cyc(HRD, 0);
    check("r28_count", int'(count), 3);
    check("r28_head", int'(cmd_code), 1);
    cyc('0, 1);
    check("r28_pop1", int'(cmd_code), 3);
    cyc('0, 1);
    check("r28_pop2", int'(cmd_code), 5);
    cyc('0, 1);
    check("r28_empty", int'(count), 0);

    cyc(PAU | SEL, 0);
    check("r29_pause", int'(cmd_code), 7);
    cyc(SEL | HLD, 0);
    check("r29_count", int'(count), 2);
    cyc('0, 1);
    check("r29_hold", int'(cmd_code), 6);
    cyc('0, 1);

    cyc(LFT, 0);
    cyc(ROT, 0);
    cyc(HRD, 0);
    cyc(HLD, 0);
    cyc(ROT, 0);
    check("r30_full", int'(count), 4);
    check("r30_ovf", int'(overflow), 1);
    check("r30_stable", int'(cmd_code), 1);
    cyc(ROT, 1);
    check("r30_pushpop", int'(count), 4);
    check("r30_head", int'(cmd_code), 3);

    cyc('0, 1);
    check("r31_pre", int'(count), 3);
    cyc(RST, 1);
    check("r31_count", int'(count), 1);
    check("r31_code", int'(cmd_code), 9);
    check("r31_ovf", int'(overflow), 0);
    cyc('0, 1);

    cyc(LFT | RGT | SFT, 0);
    check("r32_count", int'(count), 1);
    check("r32_code", int'(cmd_code), 4);
    game_active = 1'b0;
    cyc(ROT, 0);
    check("r32_menu", int'(count), 1);
    cyc(SEL | PAU, 0);
    check("r32_sel", int'(count), 2);
    game_active = 1'b1;
    cyc('0, 1);
    cyc('0, 1);

    cyc(LFT, 0);
    cyc(RGT, 0);
    check("r33_pre", int'(count), 2);
    async_rst("r33");

    for (int i = 0; i < 3000; i++) begin
      b = '0;
      for (int k = 1; k < 9; k++)
        if ($urandom_range(5) == 0) b[k] = 1'b1;
      if ($urandom_range(60) == 0) b[0] = 1'b1;
      if ($urandom_range(50) == 0) game_active = ~game_active;
      if (i == 1500) async_rst("rand_rst");
      cyc(b, $urandom_range(9) < 4);
    end

    repeat (2) @(posedge clk_in);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
